// File: rtl/bp_be_retire_gen_dual_pkg.sv
// Shared types for the dual-lane retire generator: exception/special encodings and stage records.
// Optional feature macro used by the top: BP_BE_RETIRE_PERF_EN.
package bp_be_retire_gen_dual_pkg;

   localparam int dpath_width_gp = 64;

   typedef struct packed {
      logic ecall;
      logic store_fault;
      logic store_misaligned;
      logic load_fault;
      logic load_misaligned;
      logic breakpoint;
      logic illegal_instr;
      logic instr_access_fault;
      logic instr_misaligned;
   } bp_be_exception_s;

   typedef struct packed {
      logic sfence_vma;
      logic wfi;
      logic fence;
      logic sret;
      logic mret;
   } bp_be_special_s;

   localparam int exception_width_lp = $bits(bp_be_exception_s);
   localparam int special_width_lp   = $bits(bp_be_special_s);

   typedef enum logic {
      e_run   = 1'b0,
      e_block = 1'b1
   } bp_be_retire_state_e;

   typedef struct packed {
      logic                          v;
      logic                          queue_v;
      logic [exception_width_lp-1:0] exception;
      logic [special_width_lp-1:0]   special;
   } bp_be_retire_ex1_s;

   typedef struct packed {
      logic                          v;
      logic                          queue_v;
      logic [exception_width_lp-1:0] exception;
      logic [special_width_lp-1:0]   special;
      logic [dpath_width_gp-1:0]     data;
   } bp_be_retire_slot_s;

   // A valid slot carrying any exception or special op forces a redirect from commit.
   function automatic logic slot_traps(bp_be_retire_slot_s s);
      return s.v & ((|s.exception) | (|s.special));
   endfunction

endpackage

// File: rtl/bp_be_retire_gen_dual_if.sv
// Dispatch/ex1 inputs and retire outputs of the dual-lane retire generator.
// The BP_BE_RETIRE_PERF_EN counters are plain top-level ports, so this interface is build-independent.
interface bp_be_retire_gen_dual_if;
   import bp_be_retire_gen_dual_pkg::*;

   logic                          flush_i;
   logic                          dispatch_v_i;
   logic                          dispatch_v_i2;
   logic                          dispatch_queue_v_i;
   logic                          dispatch_queue_v_i2;
   logic [exception_width_lp-1:0] dispatch_exception_i;
   logic [exception_width_lp-1:0] dispatch_exception_i2;
   logic [special_width_lp-1:0]   dispatch_special_i;
   logic [special_width_lp-1:0]   dispatch_special_i2;
   logic [exception_width_lp-1:0] late_exception_i;
   logic [exception_width_lp-1:0] late_exception_i2;
   logic [dpath_width_gp-1:0]     wb_data_i;
   logic [dpath_width_gp-1:0]     wb_data_i2;

   logic                          retire_v_o;
   logic                          retire_v_o2;
   logic                          retire_queue_v_o;
   logic                          retire_queue_v_o2;
   logic [dpath_width_gp-1:0]     retire_data_o;
   logic [dpath_width_gp-1:0]     retire_data_o2;
   logic [exception_width_lp-1:0] retire_exception_o;
   logic [exception_width_lp-1:0] retire_exception_o2;
   logic [special_width_lp-1:0]   retire_special_o;
   logic [special_width_lp-1:0]   retire_special_o2;
   logic                          blocked_o;

   modport master (
      output flush_i, dispatch_v_i, dispatch_v_i2, dispatch_queue_v_i, dispatch_queue_v_i2,
             dispatch_exception_i, dispatch_exception_i2, dispatch_special_i, dispatch_special_i2,
             late_exception_i, late_exception_i2, wb_data_i, wb_data_i2,
      input  retire_v_o, retire_v_o2, retire_queue_v_o, retire_queue_v_o2,
             retire_data_o, retire_data_o2, retire_exception_o, retire_exception_o2,
             retire_special_o, retire_special_o2, blocked_o
   );

   modport slave (
      input  flush_i, dispatch_v_i, dispatch_v_i2, dispatch_queue_v_i, dispatch_queue_v_i2,
             dispatch_exception_i, dispatch_exception_i2, dispatch_special_i, dispatch_special_i2,
             late_exception_i, late_exception_i2, wb_data_i, wb_data_i2,
      output retire_v_o, retire_v_o2, retire_queue_v_o, retire_queue_v_o2,
             retire_data_o, retire_data_o2, retire_exception_o, retire_exception_o2,
             retire_special_o, retire_special_o2, blocked_o
   );

endinterface

// File: rtl/bp_be_retire_gen_dual_slot.sv
// One retire lane: ex1/ex2 registers, late-exception merge and output kill.
// Instantiated twice by bp_be_retire_gen_dual.
module bp_be_retire_gen_dual_slot
   import bp_be_retire_gen_dual_pkg::*;
  (input  logic                          clk_i
   ,input  logic                          reset_i
   ,input  logic                          clear_i
   ,input  logic                          dispatch_v_i
   ,input  logic                          dispatch_queue_v_i
   ,input  logic [exception_width_lp-1:0] dispatch_exception_i
   ,input  logic [special_width_lp-1:0]   dispatch_special_i
   ,input  logic [exception_width_lp-1:0] late_exception_i
   ,input  logic [dpath_width_gp-1:0]     wb_data_i
   ,input  logic                          kill_i
   ,output bp_be_retire_slot_s            retire_o
   );

   bp_be_retire_ex1_s  ex1_d, ex1_q;
   bp_be_retire_slot_s ex2_d, ex2_q;

   always_comb begin
      ex1_d = '0;
      if (!clear_i && dispatch_v_i) begin
         ex1_d.v         = 1'b1;
         ex1_d.queue_v   = dispatch_queue_v_i;
         ex1_d.exception = dispatch_exception_i;
         ex1_d.special   = dispatch_special_i;
      end
   end

   always_comb begin
      ex2_d = '0;
      if (!clear_i && ex1_q.v) begin
         ex2_d.v         = 1'b1;
         ex2_d.queue_v   = ex1_q.queue_v;
         ex2_d.exception = ex1_q.exception | late_exception_i;
         ex2_d.special   = ex1_q.special;
         ex2_d.data      = wb_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ex1_q <= '0;
         ex2_q <= '0;
      end else begin
         ex1_q <= ex1_d;
         ex2_q <= ex2_d;
      end
   end

   // A trapping instruction never frees its fe-queue entry; commit replays it.
   always_comb begin
      retire_o = '0;
      if (ex2_q.v && !kill_i) begin
         retire_o         = ex2_q;
         retire_o.queue_v = ex2_q.queue_v & ~(|ex2_q.exception);
      end
   end

endmodule

// File: rtl/bp_be_retire_gen_dual.sv
// Dual-lane retire generator: two-stage slot pipes, intra-pair kill and trap-block FSM.
// Define BP_BE_RETIRE_PERF_EN to add the instret/dual-retire counters.
//
// state   | meaning
// e_run   | retiring normally
// e_block | trap retired; pipe held empty until commit flushes
module bp_be_retire_gen_dual
   import bp_be_retire_gen_dual_pkg::*;
  (input  logic clk_i
   ,input  logic reset_i
`ifdef BP_BE_RETIRE_PERF_EN
   ,output logic [63:0] instret_cnt_o
   ,output logic [63:0] dual_retire_cnt_o
`endif
   ,bp_be_retire_gen_dual_if.slave retire_if
   );

   bp_be_retire_state_e state_q, state_d;
   bp_be_retire_slot_s  ret1, ret2;
   logic                run, clear, trap1, trap2;

   // Entries younger than a trap must never reach retire, so clearing follows the next state.
   assign clear = retire_if.flush_i | (state_d == e_block);
   assign trap1 = slot_traps(ret1);
   assign trap2 = slot_traps(ret2);

   bp_be_retire_gen_dual_slot slot1 (
      .clk_i                (clk_i)
      ,.reset_i              (reset_i)
      ,.clear_i              (clear)
      ,.dispatch_v_i         (retire_if.dispatch_v_i)
      ,.dispatch_queue_v_i   (retire_if.dispatch_queue_v_i)
      ,.dispatch_exception_i (retire_if.dispatch_exception_i)
      ,.dispatch_special_i   (retire_if.dispatch_special_i)
      ,.late_exception_i     (retire_if.late_exception_i)
      ,.wb_data_i            (retire_if.wb_data_i)
      ,.kill_i               (~run)
      ,.retire_o             (ret1)
   );

   // Lane 2 without lane 1 breaks age ordering and is dropped.
   bp_be_retire_gen_dual_slot slot2 (
      .clk_i                (clk_i)
      ,.reset_i              (reset_i)
      ,.clear_i              (clear)
      ,.dispatch_v_i         (retire_if.dispatch_v_i2 & retire_if.dispatch_v_i)
      ,.dispatch_queue_v_i   (retire_if.dispatch_queue_v_i2)
      ,.dispatch_exception_i (retire_if.dispatch_exception_i2)
      ,.dispatch_special_i   (retire_if.dispatch_special_i2)
      ,.late_exception_i     (retire_if.late_exception_i2)
      ,.wb_data_i            (retire_if.wb_data_i2)
      ,.kill_i               (~run | trap1)
      ,.retire_o             (ret2)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= e_run;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         e_run:   if (!retire_if.flush_i && (trap1 || trap2)) state_d = e_block;
         e_block: if (retire_if.flush_i) state_d = e_run;
         default: state_d = e_run;
      endcase
   end

   always_comb begin
      run                 = (state_q == e_run);
      retire_if.blocked_o = ~run;
   end

   assign retire_if.retire_v_o          = ret1.v;
   assign retire_if.retire_queue_v_o    = ret1.queue_v;
   assign retire_if.retire_data_o       = ret1.data;
   assign retire_if.retire_exception_o  = ret1.exception;
   assign retire_if.retire_special_o    = ret1.special;
   assign retire_if.retire_v_o2         = ret2.v;
   assign retire_if.retire_queue_v_o2   = ret2.queue_v;
   assign retire_if.retire_data_o2      = ret2.data;
   assign retire_if.retire_exception_o2 = ret2.exception;
   assign retire_if.retire_special_o2   = ret2.special;

`ifdef BP_BE_RETIRE_PERF_EN
   logic [63:0] instret_cnt_q, instret_cnt_d;
   logic [63:0] dual_retire_cnt_q, dual_retire_cnt_d;
   logic        clean1, clean2;

   always_comb begin
      clean1            = ret1.v & ~(|ret1.exception);
      clean2            = ret2.v & ~(|ret2.exception);
      instret_cnt_d     = instret_cnt_q + 64'(clean1) + 64'(clean2);
      dual_retire_cnt_d = dual_retire_cnt_q + 64'(clean1 & clean2);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         instret_cnt_q     <= '0;
         dual_retire_cnt_q <= '0;
      end else begin
         instret_cnt_q     <= instret_cnt_d;
         dual_retire_cnt_q <= dual_retire_cnt_d;
      end
   end

   assign instret_cnt_o     = instret_cnt_q;
   assign dual_retire_cnt_o = dual_retire_cnt_q;
`endif

   lane2_needs_lane1_a: assert property (@(posedge clk_i) disable iff (reset_i)
      retire_if.dispatch_v_i2 |-> retire_if.dispatch_v_i);

endmodule

// File: tb/tb_bp_be_retire_gen_dual.sv
// Self-checking bench for bp_be_retire_gen_dual: directed scenarios plus random traffic
// against a queue-of-pairs reference model (BP_BE_RETIRE_PERF_EN optional).
module tb_bp_be_retire_gen_dual;
   import bp_be_retire_gen_dual_pkg::*;

   localparam int EW = exception_width_lp;
   localparam int SW = special_width_lp;
   localparam int DW = dpath_width_gp;

   logic clk_i   = 1'b0;
   logic reset_i = 1'b1;

   bp_be_retire_gen_dual_if rif();

`ifdef BP_BE_RETIRE_PERF_EN
   logic [63:0] instret_cnt_o, dual_retire_cnt_o;
`endif

   bp_be_retire_gen_dual dut (
      .clk_i              (clk_i)
      ,.reset_i            (reset_i)
`ifdef BP_BE_RETIRE_PERF_EN
      ,.instret_cnt_o      (instret_cnt_o)
      ,.dual_retire_cnt_o  (dual_retire_cnt_o)
`endif
      ,.retire_if          (rif)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model: pairs in flight, each tagged with its dispatch cycle.
   typedef struct {
      longint          born;
      bit              v2, q1, q2;
      logic [EW-1:0]   e1, e2;
      logic [SW-1:0]   s1, s2;
      logic [DW-1:0]   d1, d2;
   } pair_t;

   pair_t           pipe[$];
   bit              blocked_m = 1'b0;
   longint          cyc = 0;
   logic [63:0]     instret_m = '0, dual_m = '0;

   bit              xv1, xv2, xq1, xq2;
   logic [EW-1:0]   xe1, xe2;
   logic [SW-1:0]   xs1, xs2;
   logic [DW-1:0]   xd1, xd2;

   function automatic void predict();
      pair_t p;
      xv1 = 0; xv2 = 0; xq1 = 0; xq2 = 0;
      xe1 = '0; xe2 = '0; xs1 = '0; xs2 = '0; xd1 = '0; xd2 = '0;
      if (!blocked_m && pipe.size() > 0 && pipe[0].born == cyc - 2) begin
         p   = pipe[0];
         xv1 = 1; xe1 = p.e1; xs1 = p.s1; xd1 = p.d1;
         xq1 = p.q1 && (p.e1 == '0);
         if (p.v2 && p.e1 == '0 && p.s1 == '0) begin
            xv2 = 1; xe2 = p.e2; xs2 = p.s2; xd2 = p.d2;
            xq2 = p.q2 && (p.e2 == '0);
         end
      end
   endfunction

   function automatic void model_step();
      bit    trap;
      pair_t np;
      predict();
      trap = (xv1 && (xe1 != '0 || xs1 != '0)) || (xv2 && (xe2 != '0 || xs2 != '0));
      if (reset_i) begin
         instret_m = '0; dual_m = '0;
      end else begin
         instret_m = instret_m + 64'(xv1 && xe1 == '0) + 64'(xv2 && xe2 == '0);
         if (xv1 && xe1 == '0 && xv2 && xe2 == '0) dual_m = dual_m + 1;
      end
      if (pipe.size() > 0 && pipe[0].born == cyc - 2) void'(pipe.pop_front());
      if (reset_i || rif.flush_i) begin
         pipe.delete(); blocked_m = 0;
      end else if (blocked_m || trap) begin
         pipe.delete(); blocked_m = 1;
      end else begin
         foreach (pipe[i]) if (pipe[i].born == cyc - 1) begin
            pipe[i].e1 = pipe[i].e1 | rif.late_exception_i;
            pipe[i].e2 = pipe[i].e2 | rif.late_exception_i2;
            pipe[i].d1 = rif.wb_data_i;
            pipe[i].d2 = rif.wb_data_i2;
         end
         if (rif.dispatch_v_i) begin
            np.born = cyc;
            np.v2 = rif.dispatch_v_i2;
            np.q1 = rif.dispatch_queue_v_i;  np.q2 = rif.dispatch_queue_v_i2;
            np.e1 = rif.dispatch_exception_i; np.e2 = rif.dispatch_exception_i2;
            np.s1 = rif.dispatch_special_i;  np.s2 = rif.dispatch_special_i2;
            np.d1 = '0; np.d2 = '0;
            pipe.push_back(np);
         end
      end
      cyc++;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_i);
      #1;
      predict();
      chk("retire_v_o",          64'(rif.retire_v_o),          64'(xv1));
      chk("retire_v_o2",         64'(rif.retire_v_o2),         64'(xv2));
      chk("retire_queue_v_o",    64'(rif.retire_queue_v_o),    64'(xq1));
      chk("retire_queue_v_o2",   64'(rif.retire_queue_v_o2),   64'(xq2));
      chk("retire_exception_o",  64'(rif.retire_exception_o),  64'(xe1));
      chk("retire_exception_o2", 64'(rif.retire_exception_o2), 64'(xe2));
      chk("retire_special_o",    64'(rif.retire_special_o),    64'(xs1));
      chk("retire_special_o2",   64'(rif.retire_special_o2),   64'(xs2));
      chk("retire_data_o",       rif.retire_data_o,            xd1);
      chk("retire_data_o2",      rif.retire_data_o2,           xd2);
      chk("blocked_o",           64'(rif.blocked_o),           64'(blocked_m));
`ifdef BP_BE_RETIRE_PERF_EN
      chk("instret_cnt_o",       instret_cnt_o,                instret_m);
      chk("dual_retire_cnt_o",   dual_retire_cnt_o,            dual_m);
`endif
   endtask

   task automatic set_idle();
      reset_i                   = 1'b0;
      rif.flush_i               = 1'b0;
      rif.dispatch_v_i          = 1'b0;
      rif.dispatch_v_i2         = 1'b0;
      rif.dispatch_queue_v_i    = 1'b0;
      rif.dispatch_queue_v_i2   = 1'b0;
      rif.dispatch_exception_i  = '0;
      rif.dispatch_exception_i2 = '0;
      rif.dispatch_special_i    = '0;
      rif.dispatch_special_i2   = '0;
      rif.late_exception_i      = '0;
      rif.late_exception_i2     = '0;
      rif.wb_data_i             = '0;
      rif.wb_data_i2            = '0;
   endtask

   task automatic dispatch_pair(input logic [EW-1:0] e1, input logic [EW-1:0] e2);
      set_idle();
      rif.dispatch_v_i = 1'b1; rif.dispatch_v_i2 = 1'b1;
      rif.dispatch_queue_v_i = 1'b1; rif.dispatch_queue_v_i2 = 1'b1;
      rif.dispatch_exception_i = e1; rif.dispatch_exception_i2 = e2;
   endtask

   function automatic logic [EW-1:0] exc_load_fault();
      bp_be_exception_s e;
      e = '0; e.load_fault = 1'b1;
      return e;
   endfunction

   function automatic logic [EW-1:0] exc_illegal();
      bp_be_exception_s e;
      e = '0; e.illegal_instr = 1'b1;
      return e;
   endfunction

   initial begin
      set_idle();
      reset_i = 1'b1;
      tick(); tick();
      chk("reset_blocked", 64'(rif.blocked_o), 64'd0);
      chk("reset_v",       64'(rif.retire_v_o), 64'd0);

      // Dual retire
      set_idle(); tick();
      dispatch_pair('0, '0); tick();
      set_idle(); rif.wb_data_i = 64'h11; rif.wb_data_i2 = 64'h22; tick();
      chk("dual_v1", 64'(rif.retire_v_o), 64'd1);
      chk("dual_v2", 64'(rif.retire_v_o2), 64'd1);
      chk("dual_data1", rif.retire_data_o, 64'h11);
      chk("dual_data2", rif.retire_data_o2, 64'h22);
      chk("dual_q1", 64'(rif.retire_queue_v_o), 64'd1);
      chk("dual_q2", 64'(rif.retire_queue_v_o2), 64'd1);

      // Late trap on slot 1
      dispatch_pair('0, '0); tick();
      set_idle(); rif.late_exception_i = exc_load_fault(); tick();
      chk("late_exc1", 64'(rif.retire_exception_o), 64'(exc_load_fault()));
      chk("late_v2",   64'(rif.retire_v_o2), 64'd0);
      chk("late_q1",   64'(rif.retire_queue_v_o), 64'd0);
      dispatch_pair('0, '0); tick();
      chk("late_blocked", 64'(rif.blocked_o), 64'd1);
      tick(); tick();
      chk("late_blocked_v", 64'(rif.retire_v_o), 64'd0);
      set_idle(); rif.flush_i = 1'b1; tick();
      chk("late_unblock", 64'(rif.blocked_o), 64'd0);

      // Slot-2-only exception
      dispatch_pair('0, exc_illegal()); tick();
      set_idle(); tick();
      chk("s2exc_v1",  64'(rif.retire_v_o), 64'd1);
      chk("s2exc_v2",  64'(rif.retire_v_o2), 64'd1);
      chk("s2exc_e2",  64'(rif.retire_exception_o2), 64'(exc_illegal()));
      chk("s2exc_q1",  64'(rif.retire_queue_v_o), 64'd1);
      tick();
      chk("s2exc_blocked", 64'(rif.blocked_o), 64'd1);
      rif.flush_i = 1'b1; tick();

      // Flush mid-flight
      dispatch_pair('0, '0); tick();
      dispatch_pair('0, '0); rif.flush_i = 1'b1; tick();
      chk("flush_t2", 64'(rif.retire_v_o), 64'd0);
      dispatch_pair('0, '0); tick();
      chk("flush_t3", 64'(rif.retire_v_o), 64'd0);
      set_idle(); rif.wb_data_i = 64'h5a; tick();
      chk("flush_t4_v",    64'(rif.retire_v_o), 64'd1);
      chk("flush_t4_data", rif.retire_data_o, 64'h5a);

      // Reset mid-flight
      dispatch_pair('0, '0); tick();
      set_idle(); reset_i = 1'b1; tick();
      chk("rst_t2", 64'(rif.retire_v_o), 64'd0);
      set_idle(); tick();
      chk("rst_t3", 64'(rif.retire_v_o), 64'd0);
      chk("rst_t3_blocked", 64'(rif.blocked_o), 64'd0);

`ifdef BP_BE_RETIRE_PERF_EN
      set_idle(); reset_i = 1'b1; tick();
      for (int k = 0; k < 4; k++) begin
         dispatch_pair((k == 3) ? exc_illegal() : '0, '0);
         tick();
      end
      set_idle(); tick(); tick(); tick();
      chk("perf_instret", instret_cnt_o, 64'd6);
      chk("perf_dual",    dual_retire_cnt_o, 64'd3);
      rif.flush_i = 1'b1; tick();
`endif

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         set_idle();
         rif.dispatch_v_i          = ($urandom_range(0, 9) < 7);
         rif.dispatch_v_i2         = rif.dispatch_v_i & 1'($urandom_range(0, 1));
         rif.dispatch_queue_v_i    = 1'($urandom_range(0, 1));
         rif.dispatch_queue_v_i2   = 1'($urandom_range(0, 1));
         rif.dispatch_exception_i  = ($urandom_range(0, 15) == 0) ? EW'($urandom) : '0;
         rif.dispatch_exception_i2 = ($urandom_range(0, 15) == 0) ? EW'($urandom) : '0;
         rif.dispatch_special_i    = ($urandom_range(0, 19) == 0) ? SW'($urandom) : '0;
         rif.dispatch_special_i2   = ($urandom_range(0, 19) == 0) ? SW'($urandom) : '0;
         rif.late_exception_i      = ($urandom_range(0, 15) == 0) ? EW'($urandom) : '0;
         rif.late_exception_i2     = ($urandom_range(0, 15) == 0) ? EW'($urandom) : '0;
         rif.wb_data_i             = {$urandom, $urandom};
         rif.wb_data_i2            = {$urandom, $urandom};
         rif.flush_i               = ($urandom_range(0, 14) == 0);
         reset_i                   = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
